tx_packet_encoder: RTL and testbench

Transmit counterpart of rxPacketDecoder. Accepts a frame of NUM_BYTES payload bytes over a valid/ready handshake and emits one serial sample stream on data_out, one sample per enClk-qualified clock. The stream is a Barker-13 preamble followed by Barker-7 spread data symbols. It feeds the modulator/DAC path and produces exactly the sample stream rxPacketDecoder expects on its data_in.

---
 rtl/tx_packet_pkg.sv | 23 ++
 rtl/tx_packet_encoder_crc8_serial.sv | 20 ++
 rtl/tx_packet_encoder.sv | 197 +++++++++++++++++++
 tb/tb_tx_packet_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_packet_pkg.sv
// Shared constants, state encoding and CRC polynomial for the packet transmitter.
package tx_packet_pkg;

    localparam int PREAMB_LEN = 130;
    localparam int SYM_LEN    = 42;

    // Each Barker chip is held for two samples, so chip 1 -> 2'b11 and chip 0 -> 2'b00.
    localparam logic [25:0]  B13    = 26'b11001100111100001111111111;
    localparam logic [129:0] PREAMB = {B13, ~B13, ~B13, ~B13, B13};
    localparam logic [13:0]  B7     = 14'b11111100001100;
    localparam logic [41:0]  SYM    = {~B7, ~B7, B7};

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // State literals carry an S_ prefix because PREAMB is already the preamble constant.
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMB,
        S_DATA,
        S_DONE
    } state_t;

endpackage

// File: rtl/tx_packet_encoder_crc8_serial.sv
// Bytewise CRC-8 update (poly 0x07, MSB first); only instantiated when TX_CRC8_EN is defined.
module crc8_serial
    import tx_packet_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] acc;

    always_comb begin
        acc = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ({acc[6:0], 1'b0} ^ CRC8_POLY) : {acc[6:0], 1'b0};
        end
        crc_out = acc;
    end

endmodule

// File: rtl/tx_packet_encoder.sv
// Barker-13 preamble + Barker-7 spread payload transmitter (mirror of rxPacketDecoder).
// Define TX_CRC8_EN to append a CRC-8 byte after the payload.
module tx_packet_encoder
    import tx_packet_pkg::*;
#(
    parameter int NUM_BYTES = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enClk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_out,
    output logic       frame_active,
    output logic       frame_done,
    output logic       underrun
);

    state_t     state, state_next;
    logic [7:0] p_cnt;
    logic [5:0] s_cnt;
    logic [2:0] b_cnt;
    logic [7:0] k_cnt;
    logic [7:0] shift_reg;
    logic [7:0] hold_reg;
    logic       hold_full;
    logic [7:0] next_byte;

    logic preamb_end, sym_end, byte_end, last_byte, crc_slot;
    logic need_hold, starve, load_hold;
    logic data_next, active_next, done_next, underrun_next;

`ifdef TX_CRC8_EN
    logic [7:0] crc_reg;
    logic [7:0] crc_upd;

    crc8_serial u_crc (
        .crc_in  (crc_reg),
        .data    (hold_reg),
        .crc_out (crc_upd)
    );

    // crc_reg already covers every payload byte by the time the CRC slot is loaded.
    assign last_byte = (k_cnt == 8'(NUM_BYTES));
    assign crc_slot  = (k_cnt == 8'(NUM_BYTES - 1));
    assign next_byte = crc_slot ? crc_reg : hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg <= 8'h00;
        end else if (enClk) begin
            if (state == S_IDLE) begin
                crc_reg <= 8'h00;
            end else if (load_hold) begin
                crc_reg <= crc_upd;
            end
        end
    end
`else
    assign last_byte = (k_cnt == 8'(NUM_BYTES - 1));
    assign crc_slot  = 1'b0;
    assign next_byte = hold_reg;
`endif

    assign tx_ready   = ~hold_full;
    assign preamb_end = (state == S_PREAMB) && (p_cnt == 8'(PREAMB_LEN - 1));
    assign sym_end    = (s_cnt == 6'(SYM_LEN - 1));
    assign byte_end   = (state == S_DATA) && sym_end && (b_cnt == 3'd7);
    assign need_hold  = byte_end && !last_byte && !crc_slot;
    assign starve     = need_hold && !hold_full;
    assign load_hold  = preamb_end || (need_hold && hold_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (enClk) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (hold_full) state_next = S_PREAMB;
            S_PREAMB: if (preamb_end) state_next = S_DATA;
            S_DATA: begin
                if (byte_end && last_byte) begin
                    state_next = S_DONE;
                end else if (starve) begin
                    state_next = S_IDLE;
                end
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // The IDLE->PREAMB edge already emits PREAMB[129], so PREAMB itself covers p = 1..129.
    always_comb begin
        data_next     = 1'b0;
        active_next   = 1'b0;
        done_next     = 1'b0;
        underrun_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    data_next   = PREAMB[PREAMB_LEN - 1];
                    active_next = 1'b1;
                end
            end
            S_PREAMB: begin
                data_next   = PREAMB[8'(PREAMB_LEN - 1) - p_cnt];
                active_next = 1'b1;
            end
            S_DATA: begin
                if (starve) begin
                    underrun_next = 1'b1;
                end else begin
                    data_next   = SYM[6'(SYM_LEN - 1) - s_cnt] ^ ~shift_reg[7];
                    active_next = 1'b1;
                end
            end
            default: done_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out     <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (enClk) begin
                data_out     <= data_next;
                frame_active <= active_next;
                frame_done   <= done_next;
                underrun     <= underrun_next;
            end
        end
    end

    // The handshake runs on every clk edge; consumption of the holding register needs enClk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= 8'h00;
            hold_full <= 1'b0;
            shift_reg <= 8'h00;
            p_cnt     <= 8'd0;
            s_cnt     <= 6'd0;
            b_cnt     <= 3'd0;
            k_cnt     <= 8'd0;
        end else begin
            if (enClk && load_hold) begin
                hold_full <= 1'b0;
            end
            if (tx_valid && !hold_full) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end
            if (enClk) begin
                case (state)
                    S_IDLE: begin
                        p_cnt <= 8'd1;
                        s_cnt <= 6'd0;
                        b_cnt <= 3'd0;
                        k_cnt <= 8'd0;
                    end
                    S_PREAMB: begin
                        p_cnt <= p_cnt + 8'd1;
                        if (preamb_end) begin
                            shift_reg <= hold_reg;
                        end
                    end
                    S_DATA: begin
                        if (sym_end) begin
                            s_cnt <= 6'd0;
                            b_cnt <= b_cnt + 3'd1;
                            if (b_cnt == 3'd7) begin
                                shift_reg <= next_byte;
                                k_cnt     <= k_cnt + 8'd1;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                            end
                        end else begin
                            s_cnt <= s_cnt + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_packet_encoder.sv
// Self-checking bench for tx_packet_encoder: sample stream compared against a chip-level model.
module tb_tx_packet_encoder;

    localparam int NB = 21;
`ifdef TX_CRC8_EN
    localparam int FB = NB + 1;
`else
    localparam int FB = NB;
`endif
    localparam int FRAME_LEN = 130 + FB * 336;

    logic       clk;
    logic       rst;
    logic       enClk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       data_out;
    logic       frame_active;
    logic       frame_done;
    logic       underrun;

    int checks;
    int errors;

    logic [7:0] sendq[$];
    logic [7:0] sentq[$];

    // Barker chips in transmit order, one entry per chip.
    int b13c[13] = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int b7c[7]   = '{1, 1, 1, 0, 0, 1, 0};

    tx_packet_encoder #(.NUM_BYTES(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .enClk        (enClk),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .data_out     (data_out),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] crcOf(input int n);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int j = 0; j < n; j++) begin
            for (int bi = 7; bi >= 0; bi--) begin
                fb  = crc[7] ^ sentq[j][bi];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction

    // Expected sample n of the current frame, or -1 if its byte was never accepted.
    function automatic int expSample(input int n);
        int         seg, chip, d, j, bitpos, s, v;
        logic [7:0] bval;
        if (n < 130) begin
            seg  = n / 26;
            chip = (n % 26) / 2;
            v    = b13c[chip];
            if (seg >= 1 && seg <= 3) v = 1 - v;
            return v;
        end
        d      = n - 130;
        j      = d / 336;
        bitpos = 7 - (d % 336) / 42;
        s      = d % 42;
        if (j < NB) begin
            if (j >= sentq.size()) return -1;
            bval = sentq[j];
        end else begin
            bval = crcOf(NB);
        end
        v = b7c[(s % 14) / 2];
        if (s / 14 < 2) v = 1 - v;
        return bval[bitpos] ? v : 1 - v;
    endfunction

    task automatic applyStimulus(input bit en, output bit xfer);
        logic rdy;
        enClk = en;
        if (sendq.size() > 0) begin
            tx_valid = 1'b1;
            tx_data  = sendq[0];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
        rdy = tx_ready;
        @(posedge clk);
        #1;
        xfer = tx_valid && rdy;
        if (xfer) sentq.push_back(sendq.pop_front());
    endtask

    // Runs one frame; underrun_at < 0 means a complete frame is expected.
    task automatic runFrame(input int period, input int underrun_at, input string name);
        int   idx = 0, cyc = 0, mism = 0, holdErr = 0, e;
        int   budget = (FRAME_LEN + 20) * period + 200;
        bit   armed, started = 0, xfer, en, finished = 0, gotDone = 0, gotUnder = 0;
        logic prev;
        armed = (sentq.size() > 0);
        prev  = data_out;
        while (!finished && cyc < budget) begin
            en = ((cyc % period) == 0);
            applyStimulus(en, xfer);
            cyc++;
            if (en) begin
                if (armed && !started) begin
                    checkOutput({name, "_start"}, frame_active, 1);
                    checkOutput({name, "_first_sample"}, data_out, 1);
                    started = 1;
                end
                if (frame_active === 1'b1) begin
                    e = expSample(idx);
                    if (idx >= FRAME_LEN || e < 0 || data_out !== e[0]) mism++;
                    idx++;
                end
                if (frame_done === 1'b1) begin gotDone = 1; finished = 1; end
                if (underrun === 1'b1) begin gotUnder = 1; finished = 1; end
            end else begin
                if (data_out !== prev) holdErr++;
                if (frame_done !== 1'b0 || underrun !== 1'b0) holdErr++;
            end
            prev = data_out;
            if (xfer && !armed) armed = 1;
        end
        checkOutput({name, "_finished_in_budget"}, finished, 1);
        checkOutput({name, "_sample_errors"}, mism, 0);
        if (period > 1) checkOutput({name, "_hold_errors"}, holdErr, 0);
        if (underrun_at < 0) begin
            checkOutput({name, "_frame_done"}, gotDone, 1);
            checkOutput({name, "_no_underrun"}, gotUnder, 0);
            checkOutput({name, "_frame_len"}, idx, FRAME_LEN);
            checkOutput({name, "_active_after_done"}, frame_active, 0);
            repeat (NB) if (sentq.size() > 0) void'(sentq.pop_front());
        end else begin
            checkOutput({name, "_underrun"}, gotUnder, 1);
            checkOutput({name, "_no_frame_done"}, gotDone, 0);
            checkOutput({name, "_samples_before_underrun"}, idx, underrun_at);
            checkOutput({name, "_active_at_underrun"}, frame_active, 0);
            applyStimulus(1'b1, xfer);
            checkOutput({name, "_data_after_underrun"}, data_out, 0);
            checkOutput({name, "_underrun_one_pulse"}, underrun, 0);
            checkOutput({name, "_idle_after_underrun"}, frame_active, 0);
            sentq.delete();
        end
    endtask

    initial begin
        bit xfer;
        int cnt;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        enClk    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_data_out", data_out, 0);
        checkOutput("reset_frame_active", frame_active, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_underrun", underrun, 0);
        checkOutput("reset_tx_ready", tx_ready, 1);
        rst = 1'b0;

        repeat (500) applyStimulus(1'b1, xfer);
        checkOutput("idle_data_out", data_out, 0);
        checkOutput("idle_frame_active", frame_active, 0);

        $display("[TB] frame 1: 21 bytes 0xBE downward, enClk=1");
        for (int i = 0; i < NB; i++) sendq.push_back(8'(8'hBE - i));
        runFrame(1, -1, "frame1");

        $display("[TB] frame 2: random bytes plus one extra, enClk 1-of-4");
        for (int i = 0; i < NB + 1; i++) sendq.push_back(8'($urandom_range(0, 255)));
        runFrame(4, -1, "frame2");
        checkOutput("leftover_byte_held", tx_ready, 0);

        $display("[TB] frame 3: leftover byte starts frame, third byte withheld");
        sendq.push_back(8'($urandom_range(0, 255)));
        runFrame(1, 130 + 2 * 336 - 1, "underrun");
        checkOutput("tx_ready_after_underrun", tx_ready, 1);

        $display("[TB] frame 4: reset asserted at sample 1000");
        for (int i = 0; i < NB; i++) sendq.push_back(8'($urandom_range(0, 255)));
        cnt = 0;
        for (int c = 0; c < 3000 && cnt < 1000; c++) begin
            applyStimulus(1'b1, xfer);
            if (frame_active === 1'b1) cnt++;
        end
        checkOutput("reached_sample_1000", cnt, 1000);
        tx_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_data_out", data_out, 0);
        checkOutput("async_reset_frame_active", frame_active, 0);
        checkOutput("async_reset_tx_ready", tx_ready, 1);
        checkOutput("async_reset_frame_done", frame_done, 0);
        checkOutput("async_reset_underrun", underrun, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sendq.delete();
        sentq.delete();

        $display("[TB] frame 5: fresh frame after reset");
        for (int i = 0; i < NB; i++) sendq.push_back(8'($urandom_range(0, 255)));
        runFrame(1, -1, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
